// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// layer_sequencer : load / weight-read / position-scan / drain sequencer for a
// multi-layer conv engine. Optional POOL pass built in when SEQ_POOL_EN is defined.
// Rev 1.0
// ============================================================================
module layer_sequencer #(
   parameter int IMG_PIX  = 784,
   parameter int CNT_W    = 5,
   parameter int GRP_W    = 8,
   parameter int WA_W     = 11,
   parameter int BA_W     = 7,
   parameter int W_READS  = 4,
   parameter int PIPE_LAT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             stall,
   input  logic [2:0]       cfg_layers,
   input  logic [CNT_W-1:0] cfg_dim,
   input  logic [GRP_W-1:0] cfg_grps,
   output logic             busy,
   output logic             load_en,
   output logic             rd_w,
   output logic [WA_W-1:0]  w_addr,
   output logic [BA_W-1:0]  b_addr,
   output logic             pos_valid,
   output logic [CNT_W-1:0] x_cnt,
   output logic [CNT_W-1:0] y_cnt,
   output logic [2:0]       layer_idx,
   output logic [GRP_W-1:0] grp_cnt,
   output logic             wr_en,
   output logic [CNT_W-1:0] wr_x,
   output logic [CNT_W-1:0] wr_y,
   output logic             layer_done,
   output logic             done
);

   localparam int LD_W = (IMG_PIX > 1)  ? $clog2(IMG_PIX)  : 1;
   localparam int RC_W = (W_READS > 1)  ? $clog2(W_READS)  : 1;
   localparam int DR_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RD_W  = 3'd2,
      S_CONV  = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5
`ifdef SEQ_POOL_EN
      ,
      S_POOL   = 3'd6,
      S_PDRAIN = 3'd7
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       layers_q, layers_d;
   logic [CNT_W-1:0] dim_q, dim_d;
   logic [GRP_W-1:0] grps_q, grps_d;
   logic [LD_W-1:0]  ld_cnt_q, ld_cnt_d;
   logic [RC_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic [DR_W-1:0]  dr_cnt_q, dr_cnt_d;
   logic [WA_W-1:0]  w_addr_q, w_addr_d;
   logic [BA_W-1:0]  b_addr_q, b_addr_d;
   logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
   logic [2:0]       layer_q, layer_d;
   logic [GRP_W-1:0] grp_q, grp_d;

   logic [PIPE_LAT-1:0]            pv_q;
   logic [PIPE_LAT-1:0][CNT_W-1:0] px_q, py_q;

   // Per-layer geometry: D shrinks by one per layer (floor of 1), G grows 4x
   logic [2:0]       layers_eff;
   logic [CNT_W-1:0] layer_ext, dim_cur, dim_last;
   logic [GRP_W-1:0] grp_tot, grp_last;
   logic             last_layer;

   assign layers_eff = (layers_q == 3'd0) ? 3'd1 : layers_q;
   assign layer_ext  = CNT_W'(layer_q);
   assign dim_cur    = (dim_q > layer_ext) ? (dim_q - layer_ext) : CNT_W'(1);
   assign dim_last   = dim_cur - CNT_W'(1);
   assign grp_tot    = grps_q << {layer_q, 1'b0};
   assign grp_last   = grp_tot - GRP_W'(1);
   assign last_layer = (layer_q == (layers_eff - 3'd1));

`ifdef SEQ_POOL_EN
   logic [2:0]       fin_idx;
   logic [CNT_W-1:0] fin_ext, fin_dim, pool_dim, pool_last;

   assign fin_idx   = layers_eff - 3'd1;
   assign fin_ext   = CNT_W'(fin_idx);
   assign fin_dim   = (dim_q > fin_ext) ? (dim_q - fin_ext) : CNT_W'(1);
   assign pool_dim  = fin_dim >> 1;
   assign pool_last = pool_dim - CNT_W'(1);
`endif

   always_comb begin
      state_d    = state_q;
      layers_d   = layers_q;
      dim_d      = dim_q;
      grps_d     = grps_q;
      ld_cnt_d   = ld_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      dr_cnt_d   = dr_cnt_q;
      w_addr_d   = w_addr_q;
      b_addr_d   = b_addr_q;
      x_d        = x_q;
      y_d        = y_q;
      layer_d    = layer_q;
      grp_d      = grp_q;
      load_en    = 1'b0;
      rd_w       = 1'b0;
      pos_valid  = 1'b0;
      layer_done = 1'b0;
      done       = 1'b0;
      if (!stall) begin
         unique case (state_q)
            S_IDLE: begin
               if (enable) begin
                  // Addresses restart at zero for every new sequence
                  layers_d = cfg_layers;
                  dim_d    = cfg_dim;
                  grps_d   = cfg_grps;
                  ld_cnt_d = '0;
                  w_addr_d = '0;
                  b_addr_d = '0;
                  layer_d  = '0;
                  grp_d    = '0;
                  state_d  = S_LOAD;
               end
            end
            S_LOAD: begin
               load_en = 1'b1;
               if (ld_cnt_q == LD_W'(IMG_PIX - 1)) begin
                  ld_cnt_d = '0;
                  state_d  = S_RD_W;
               end else begin
                  ld_cnt_d = ld_cnt_q + LD_W'(1);
               end
            end
            S_RD_W: begin
               rd_w     = 1'b1;
               w_addr_d = w_addr_q + WA_W'(1);
               if (rd_cnt_q == RC_W'(W_READS - 1)) begin
                  rd_cnt_d = '0;
                  b_addr_d = b_addr_q + BA_W'(1);
                  state_d  = S_CONV;
               end else begin
                  rd_cnt_d = rd_cnt_q + RC_W'(1);
               end
            end
            S_CONV: begin
               pos_valid = 1'b1;
               if (x_q == dim_last) begin
                  x_d = '0;
                  if (y_q == dim_last) begin
                     y_d     = '0;
                     state_d = S_DRAIN;
                  end else begin
                     y_d = y_q + CNT_W'(1);
                  end
               end else begin
                  x_d = x_q + CNT_W'(1);
               end
            end
            S_DRAIN: begin
               if (dr_cnt_q == DR_W'(PIPE_LAT - 1)) begin
                  dr_cnt_d = '0;
                  if (grp_q != grp_last) begin
                     grp_d   = grp_q + GRP_W'(1);
                     state_d = S_RD_W;
                  end else begin
                     layer_done = 1'b1;
                     if (!last_layer) begin
                        grp_d   = '0;
                        layer_d = layer_q + 3'd1;
                        state_d = S_RD_W;
                     end else begin
`ifdef SEQ_POOL_EN
                        if (pool_dim != '0) begin
                           grp_d   = '0;
                           layer_d = layer_q + 3'd1;
                           state_d = S_POOL;
                        end else begin
                           state_d = S_DONE;
                        end
`else
                        state_d = S_DONE;
`endif
                     end
                  end
               end else begin
                  dr_cnt_d = dr_cnt_q + DR_W'(1);
               end
            end
`ifdef SEQ_POOL_EN
            S_POOL: begin
               pos_valid = 1'b1;
               if (x_q == pool_last) begin
                  x_d = '0;
                  if (y_q == pool_last) begin
                     y_d     = '0;
                     state_d = S_PDRAIN;
                  end else begin
                     y_d = y_q + CNT_W'(1);
                  end
               end else begin
                  x_d = x_q + CNT_W'(1);
               end
            end
            S_PDRAIN: begin
               if (dr_cnt_q == DR_W'(PIPE_LAT - 1)) begin
                  dr_cnt_d = '0;
                  state_d  = S_DONE;
               end else begin
                  dr_cnt_d = dr_cnt_q + DR_W'(1);
               end
            end
`endif
            S_DONE: begin
               done    = 1'b1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         layers_q <= '0;
         dim_q    <= '0;
         grps_q   <= '0;
         ld_cnt_q <= '0;
         rd_cnt_q <= '0;
         dr_cnt_q <= '0;
         w_addr_q <= '0;
         b_addr_q <= '0;
         x_q      <= '0;
         y_q      <= '0;
         layer_q  <= '0;
         grp_q    <= '0;
      end else begin
         state_q  <= state_d;
         layers_q <= layers_d;
         dim_q    <= dim_d;
         grps_q   <= grps_d;
         ld_cnt_q <= ld_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         dr_cnt_q <= dr_cnt_d;
         w_addr_q <= w_addr_d;
         b_addr_q <= b_addr_d;
         x_q      <= x_d;
         y_q      <= y_d;
         layer_q  <= layer_d;
         grp_q    <= grp_d;
      end
   end

   // Write-position delay line advances only on non-stalled cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pv_q <= '0;
         px_q <= '0;
         py_q <= '0;
      end else if (!stall) begin
         for (int i = PIPE_LAT - 1; i > 0; i--) begin
            pv_q[i] <= pv_q[i-1];
            px_q[i] <= px_q[i-1];
            py_q[i] <= py_q[i-1];
         end
         pv_q[0] <= pos_valid;
         px_q[0] <= x_q;
         py_q[0] <= y_q;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign w_addr    = w_addr_q;
   assign b_addr    = b_addr_q;
   assign x_cnt     = x_q;
   assign y_cnt     = y_q;
   assign layer_idx = layer_q;
   assign grp_cnt   = grp_q;
   assign wr_en     = pv_q[PIPE_LAT-1] & ~stall;
   assign wr_x      = px_q[PIPE_LAT-1];
   assign wr_y      = py_q[PIPE_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// tb_layer_sequencer : scoreboard bench for layer_sequencer; stimulus pushes the
// expected weight reads, write positions and layer/done events, a monitor pops them.
module tb_layer_sequencer;
   localparam int CNT_W = 5;
   localparam int GRP_W = 8;
   localparam int WA_W  = 11;
   localparam int BA_W  = 7;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             enable = 1'b0;
   logic             stall = 1'b0;
   logic [2:0]       cfg_layers = '0;
   logic [CNT_W-1:0] cfg_dim = '0;
   logic [GRP_W-1:0] cfg_grps = '0;
   logic             busy, load_en, rd_w, pos_valid, wr_en, layer_done, done;
   logic [WA_W-1:0]  w_addr;
   logic [BA_W-1:0]  b_addr;
   logic [CNT_W-1:0] x_cnt, y_cnt, wr_x, wr_y;
   logic [2:0]       layer_idx;
   logic [GRP_W-1:0] grp_cnt;

   layer_sequencer #(
      .IMG_PIX(784), .CNT_W(CNT_W), .GRP_W(GRP_W), .WA_W(WA_W),
      .BA_W(BA_W), .W_READS(4), .PIPE_LAT(2)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .stall(stall),
      .cfg_layers(cfg_layers), .cfg_dim(cfg_dim), .cfg_grps(cfg_grps),
      .busy(busy), .load_en(load_en), .rd_w(rd_w), .w_addr(w_addr),
      .b_addr(b_addr), .pos_valid(pos_valid), .x_cnt(x_cnt), .y_cnt(y_cnt),
      .layer_idx(layer_idx), .grp_cnt(grp_cnt), .wr_en(wr_en), .wr_x(wr_x),
      .wr_y(wr_y), .layer_done(layer_done), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WA_W-1:0] waddr;
      logic [31:0]     wr_before;
   } rd_exp_t;
   typedef struct packed {
      logic [CNT_W-1:0] x;
      logic [CNT_W-1:0] y;
      logic [2:0]       layer;
      logic [GRP_W-1:0] grp;
   } wr_exp_t;
   typedef struct packed {
      logic             is_done;
      logic [2:0]       layer;
      logic [GRP_W-1:0] grp;
      logic [BA_W-1:0]  baddr;
      logic [WA_W-1:0]  waddr;
   } ev_exp_t;

   rd_exp_t rd_q[$];
   wr_exp_t wr_q[$];
   ev_exp_t ev_q[$];
   rd_exp_t re;
   wr_exp_t we;
   ev_exp_t ee;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_pops = 0;
   int load_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Monitor: pops expectations whenever the DUT presents a strobe
   always @(negedge clk) begin
      if (!rst_n || !busy) begin
         wr_pops   = 0;
         load_seen = 0;
      end else begin
         if (load_en) load_seen++;
         if (rd_w) begin
            if (rd_q.size() == 0) flag("unexpected rd_w");
            else begin
               re = rd_q.pop_front();
               chk("rd_w w_addr", 64'(w_addr), 64'(re.waddr));
               chk("rd_w load_en count", 64'(load_seen), 64'(784));
               chk("rd_w writes before", 64'(wr_pops), 64'(re.wr_before));
            end
         end
         if (wr_en) begin
            if (wr_q.size() == 0) flag("unexpected wr_en");
            else begin
               we = wr_q.pop_front();
               chk("wr_x", 64'(wr_x), 64'(we.x));
               chk("wr_y", 64'(wr_y), 64'(we.y));
               chk("wr layer_idx", 64'(layer_idx), 64'(we.layer));
               chk("wr grp_cnt", 64'(grp_cnt), 64'(we.grp));
            end
            wr_pops++;
         end
         if (layer_done || done) begin
            if (ev_q.size() == 0) flag("unexpected layer_done/done");
            else begin
               ee = ev_q.pop_front();
               chk("event is done", 64'(done), 64'(ee.is_done));
               chk("event layer_done", 64'(layer_done), 64'(!ee.is_done));
               chk("event layer_idx", 64'(layer_idx), 64'(ee.layer));
               chk("event grp_cnt", 64'(grp_cnt), 64'(ee.grp));
               chk("event b_addr", 64'(b_addr), 64'(ee.baddr));
               chk("event w_addr", 64'(w_addr), 64'(ee.waddr));
            end
         end
      end
   end

   // Reference model of one full sequence
   task automatic push_run(input int lay, input int dim, input int grps);
      int nl, w, b, nwr, d, g, last_l, last_g;
      nl = (lay == 0) ? 1 : lay;
      w = 0; b = 0; nwr = 0; d = 1; g = 1;
      for (int l = 0; l < nl; l++) begin
         d = (dim > l) ? dim - l : 1;
         g = (grps << (2 * l)) & 255;
         for (int gi = 0; gi < g; gi++) begin
            for (int r = 0; r < 4; r++) begin
               rd_q.push_back('{waddr: WA_W'(w), wr_before: 32'(nwr)});
               w = (w + 1) % 2048;
            end
            b = (b + 1) % 128;
            for (int y = 0; y < d; y++)
               for (int x = 0; x < d; x++) begin
                  wr_q.push_back('{x: CNT_W'(x), y: CNT_W'(y), layer: 3'(l), grp: GRP_W'(gi)});
                  nwr++;
               end
         end
         ev_q.push_back('{is_done: 1'b0, layer: 3'(l), grp: GRP_W'(g - 1),
                          baddr: BA_W'(b), waddr: WA_W'(w)});
      end
      last_l = nl - 1;
      last_g = g - 1;
`ifdef SEQ_POOL_EN
      if (d / 2 > 0) begin
         for (int y = 0; y < d / 2; y++)
            for (int x = 0; x < d / 2; x++)
               wr_q.push_back('{x: CNT_W'(x), y: CNT_W'(y), layer: 3'(nl), grp: GRP_W'(0)});
         last_l = nl;
         last_g = 0;
      end
`endif
      ev_q.push_back('{is_done: 1'b1, layer: 3'(last_l), grp: GRP_W'(last_g),
                       baddr: BA_W'(b), waddr: WA_W'(w)});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int lay, input int dim, input int grps);
      push_run(lay, dim, grps);
      cfg_layers = 3'(lay);
      cfg_dim    = CNT_W'(dim);
      cfg_grps   = GRP_W'(grps);
      enable     = 1'b1;
      tick();
      enable     = 1'b0;
      // Changing cfg after the start request must not affect the run
      cfg_layers = 3'd2;
      cfg_dim    = CNT_W'(9);
      cfg_grps   = GRP_W'(7);
   endtask

   task automatic wait_done(input int budget, output int done_cyc);
      int n;
      n = 0;
      done_cyc = -1;
      while (n < budget) begin
         @(negedge clk);
         if (done) begin
            done_cyc = cyc;
            break;
         end
         n++;
      end
      if (done_cyc < 0) flag("timeout waiting for done");
      tick();
      chk("busy low after done", 64'(busy), 64'(0));
      chk("done single pulse", 64'(done), 64'(0));
      chk("rd queue drained", 64'(rd_q.size()), 64'(0));
      chk("wr queue drained", 64'(wr_q.size()), 64'(0));
      chk("event queue drained", 64'(ev_q.size()), 64'(0));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " strobes"}, 64'({busy, load_en, rd_w, pos_valid, wr_en, layer_done, done}), 64'(0));
      chk({tag, " addrs"}, 64'({w_addr, b_addr}), 64'(0));
      chk({tag, " positions"}, 64'({x_cnt, y_cnt, wr_x, wr_y}), 64'(0));
      chk({tag, " layer/grp"}, 64'({layer_idx, grp_cnt}), 64'(0));
   endtask

   initial begin
      int dc, t0, n;
      bit seen;

      // Reset state
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("reset");
      tick();

      // Full default run: 3 layers, D=6, 4 groups
      start(3, 6, 4);
      n = 0; seen = 1'b0; t0 = 0;
      while (n < 1000 && !seen) begin
         @(negedge clk);
         if (pos_valid) begin seen = 1'b1; t0 = cyc; end
         n++;
      end
      if (!seen) flag("timeout waiting for first pos_valid");
      n = 0; seen = 1'b0;
      while (n < 10 && !seen) begin
         @(negedge clk);
         if (wr_en) begin
            seen = 1'b1;
            chk("first wr latency", 64'(cyc - t0), 64'(2));
            chk("first wr_x", 64'(wr_x), 64'(0));
            chk("first wr_y", 64'(wr_y), 64'(0));
         end
         n++;
      end
      if (!seen) flag("timeout waiting for first wr_en");
      wait_done(5000, dc);

      // Stall mid-CONV, plus a stray enable that must be ignored
      start(1, 6, 1);
      repeat (10) tick();
      enable = 1'b1;
      tick();
      enable = 1'b0;
      n = 0; seen = 1'b0;
      while (n < 1000 && !seen) begin
         @(negedge clk);
         if (pos_valid && x_cnt == CNT_W'(2) && y_cnt == CNT_W'(2)) seen = 1'b1;
         n++;
      end
      if (!seen) flag("timeout waiting for position (2,2)");
      @(posedge clk);
      #1;
      stall = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall x_cnt", 64'(x_cnt), 64'(3));
         chk("stall y_cnt", 64'(y_cnt), 64'(2));
         chk("stall wr_x", 64'(wr_x), 64'(1));
         chk("stall wr_y", 64'(wr_y), 64'(2));
         chk("stall pos_valid", 64'(pos_valid), 64'(0));
         chk("stall wr_en", 64'(wr_en), 64'(0));
      end
      @(posedge clk);
      #1;
      stall = 1'b0;
      wait_done(2000, dc);

      // Reset during layer 1, then restart
      start(3, 6, 4);
      n = 0; seen = 1'b0;
      while (n < 2000 && !seen) begin
         @(negedge clk);
         if (layer_idx == 3'd1) seen = 1'b1;
         n++;
      end
      if (!seen) flag("timeout waiting for layer 1");
      tick();
      repeat (5) tick();
      rst_n = 1'b0;
      rd_q.delete();
      wr_q.delete();
      ev_q.delete();
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("mid-run reset");
      repeat (10) tick();
      start(1, 2, 1);
      wait_done(2000, dc);

      // Single layer, 1x1 positions, 4 groups: done at LOAD + 4*(4+1+2)
      start(0, 1, 4);
      n = 0; seen = 1'b0; t0 = 0;
      while (n < 10 && !seen) begin
         @(negedge clk);
         if (load_en) begin seen = 1'b1; t0 = cyc; end
         n++;
      end
      if (!seen) flag("timeout waiting for load_en");
      wait_done(2000, dc);
      chk("done cycle after load", 64'(dc - t0), 64'(784 + 4 * 7));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL take parameters, one per line: name, default, meaning.
  IMG_PIX, 784, input pixels streamed in LOAD
  CNT_W, 5, width of x/y counters
  GRP_W, 8, width of group counter
  WA_W, 11, weight address width
  BA_W, 7, bias address width
  W_READS, 4, weight-read cycles per filter group
  PIPE_LAT, 2, datapath latency from position issue to write
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk  in  1  clock
  rst_n  in  1  reset
  enable  in  1  start request
  stall  in  1  freeze all sequencing
  cfg_layers  in  3  conv layer count (0 treated as 1)
  cfg_dim  in  CNT_W  first-layer output dimension
  cfg_grps  in  GRP_W  first-layer group count
  busy  out  1  sequence in progress
  load_en  out  1  input pixel accepted this cycle
  rd_w  out  1  weight-read cycle
  w_addr  out  WA_W  weight read address
  b_addr  out  BA_W  bias read address
  pos_valid  out  1  x_cnt/y_cnt is a live output position
  x_cnt, y_cnt  out  CNT_W each  current position
  layer_idx  out  3  current layer
  grp_cnt  out  GRP_W  current group
  wr_en  out  1  write strobe
  wr_x, wr_y  out  CNT_W each  write position
  layer_done  out  1  one-cycle pulse, layer complete
  done  out  1  one-cycle pulse, sequence complete
REQ-003 SHALL use one clock, clk, and a synchronous active-low reset, rst_n.

Function
REQ-004 SHALL implement the states IDLE, LOAD, RD_W, CONV, DRAIN and DONE.
REQ-005 SHALL, in IDLE with enable=1, capture the cfg_* inputs and enter LOAD; enable SHALL be ignored outside IDLE.
REQ-006 SHALL, in LOAD, assert load_en every non-stalled cycle for exactly IMG_PIX cycles and then enter RD_W with layer_idx=0 and grp_cnt=0.
REQ-007 SHALL, in RD_W, assert rd_w for W_READS cycles with w_addr incrementing by 1 after each one; w_addr SHALL be continuous across groups and layers.
REQ-008 SHALL increment b_addr once on each exit from RD_W; b_addr SHALL also be continuous.
REQ-009 SHALL, in CONV, scan the positions raster-order with x fastest: x wraps at D-1, then y increments; pos_valid SHALL be 1 throughout; after position (D-1,D-1) the block SHALL enter DRAIN.
REQ-010 SHALL set the per-layer geometry as D = cfg_dim - layer_idx and G = cfg_grps << (2*layer_idx), with a minimum D of 1.
REQ-011 SHALL hold DRAIN for PIPE_LAT cycles, then:
  - if grp_cnt < G-1: increment grp_cnt and enter RD_W;
  - else, if this is not the last layer: pulse layer_done, clear grp_cnt, increment layer_idx and enter RD_W;
  - else: pulse layer_done and enter DONE.
REQ-012 SHALL produce wr_en, wr_x and wr_y as pos_valid, x_cnt and y_cnt delayed by exactly PIPE_LAT non-stalled cycles.
REQ-013 SHALL, while stall=1, hold every register including the wr pipeline; load_en, rd_w, pos_valid and wr_en SHALL be forced to 0 for that cycle.
REQ-014 SHALL, in DONE, pulse done for one cycle and return to IDLE.
REQ-015 SHALL hold busy=1 in every state except IDLE.
REQ-016 SHALL hold x_cnt=y_cnt=0 outside CONV.
REQ-017 SHALL let w_addr and b_addr wrap modulo 2^WA_W and 2^BA_W without error.

Reset
REQ-018 SHALL, on rst_n=0 at a clock edge, go to IDLE and clear every output and counter to 0, including the wr pipeline.
REQ-019 SHALL, on a reset mid-sequence, abort without issuing further wr_en, layer_done or done.

Configuration
REQ-020 SHALL, when SEQ_POOL_EN is defined, add a POOL state between the last DRAIN and DONE:
  - scans floor(D/2) x floor(D/2) positions with pos_valid=1 and layer_idx = last layer + 1;
  - is followed by PIPE_LAT drain cycles before DONE;
  - is skipped when floor(D/2)=0.
REQ-021 SHALL, without SEQ_POOL_EN, have no POOL state and go from the last DRAIN directly to DONE.

Verification
REQ-022 SHALL cover, with defaults, cfg_layers=3, cfg_dim=6, cfg_grps=4 and enable for 1 cycle: 784 load_en cycles, then 84 groups (4+16+64), w_addr final=336, b_addr final=84, layer_done 3 times, done once.
REQ-023 SHALL cover, with layer 0 and group 0: wr_en asserted 36 times; the first wr_en occurs 2 cycles after the first pos_valid with wr_x=0 and wr_y=0; the last has wr_x=5 and wr_y=5, occurring before the next rd_w.
REQ-024 SHALL cover a 3-cycle stall asserted mid-CONV: x_cnt, y_cnt and wr_x are frozen; the total wr_en count is unchanged at 36.
REQ-025 SHALL cover rst_n=0 for 1 cycle during layer 1: busy=0 and all outputs 0 on the next cycle; a new enable restarts with w_addr=0.
REQ-026 SHALL cover cfg_layers=0 and cfg_dim=1: one layer, 1x1 positions, 4 groups, done after LOAD plus 4x(4+1+2) cycles.
REQ-027 SHALL cover, with SEQ_POOL_EN, cfg_layers=3 and cfg_dim=6: the last D=4, so POOL issues 4 positions with layer_idx=3 before done.
